// File: rtl/mod_bfly_addsub.sv
// Two-stage pipelined modular add/sub for the PE butterfly: (u+t) mod q and (u-t) mod q,
// q = 3329 (select=1) or 8380417 (select=0). Define MOD_BFLY_HALVE_EN to add half_i scaling.
module mod_bfly_addsub #(
  parameter int unsigned W       = 23,
  parameter int unsigned Q_KYBER = 3329,
  parameter int unsigned Q_DIL   = 8380417
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W-1:0] u_i,
  input  logic [W-1:0] t_i,
  input  logic         select_i,
`ifdef MOD_BFLY_HALVE_EN
  input  logic         half_i,
`endif
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] sum_o,
  output logic [W-1:0] diff_o,
  output logic         select_o,
  output logic         err_o
);

  localparam logic [W:0] QK = Q_KYBER[W:0];
  localparam logic [W:0] QD = Q_DIL[W:0];

  logic         s1_valid;
  logic         s2_valid;
  logic [W:0]   s1_sum;
  logic [W:0]   s1_diff;
  logic         s1_sel;
  logic         s1_load;
  logic         s2_load;
  logic         accept;
  logic         out_of_range;
  logic [W:0]   q_in;
  logic [W:0]   q_s1;
  logic [W-1:0] s2_sum_d;
  logic [W-1:0] s2_diff_d;
`ifdef MOD_BFLY_HALVE_EN
  logic         s1_half;
`endif

  // Single conditional subtract: raw values are < 2q for in-range operands.
  function automatic logic [W-1:0] cond_sub(input logic [W:0] x, input logic [W:0] q);
    return W'((x >= q) ? x - q : x);
  endfunction

`ifdef MOD_BFLY_HALVE_EN
  // x/2 mod q: odd values borrow q to become even before the shift.
  function automatic logic [W-1:0] halve(input logic [W-1:0] y, input logic [W:0] q);
    logic [W:0] s;
    s = y[0] ? ({1'b0, y} + q) : {1'b0, y};
    return W'(s >> 1);
  endfunction
`endif

  assign s2_load      = !s2_valid || ready_i;
  assign s1_load      = !s1_valid || s2_load;
  assign ready_o      = s1_load;
  assign accept       = valid_i && ready_o;
  assign valid_o      = s2_valid;
  assign q_in         = select_i ? QK : QD;
  assign q_s1         = s1_sel ? QK : QD;
  assign out_of_range = ({1'b0, u_i} >= q_in) || ({1'b0, t_i} >= q_in);

  always_comb begin
    s2_sum_d  = cond_sub(s1_sum, q_s1);
    s2_diff_d = cond_sub(s1_diff, q_s1);
`ifdef MOD_BFLY_HALVE_EN
    if (s1_half) begin
      s2_sum_d  = halve(s2_sum_d, q_s1);
      s2_diff_d = halve(s2_diff_d, q_s1);
    end
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_diff  <= '0;
      s1_sel   <= 1'b0;
`ifdef MOD_BFLY_HALVE_EN
      s1_half  <= 1'b0;
`endif
      s2_valid <= 1'b0;
      sum_o    <= '0;
      diff_o   <= '0;
      select_o <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_valid <= valid_i;
        if (valid_i) begin
          s1_sum  <= {1'b0, u_i} + {1'b0, t_i};
          s1_diff <= {1'b0, u_i} + q_in - {1'b0, t_i};
          s1_sel  <= select_i;
`ifdef MOD_BFLY_HALVE_EN
          s1_half <= half_i;
`endif
        end
      end
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          sum_o    <= s2_sum_d;
          diff_o   <= s2_diff_d;
          select_o <= s1_sel;
        end
      end
      if (accept && out_of_range) begin
        err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mod_bfly_addsub.sv
// Scoreboard bench for mod_bfly_addsub: accepted beats are modelled with plain modular
// arithmetic and queued; a negedge monitor pops and compares each output transfer.
module tb_mod_bfly_addsub;

  localparam int unsigned W  = 23;
  localparam int unsigned QK = 3329;
  localparam int unsigned QD = 8380417;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         valid_i;
  logic         ready_o;
  logic [W-1:0] u_i;
  logic [W-1:0] t_i;
  logic         select_i;
  logic         half_v;
  logic         valid_o;
  logic         ready_i;
  logic [W-1:0] sum_o;
  logic [W-1:0] diff_o;
  logic         select_o;
  logic         err_o;

  typedef struct {
    longint sum;
    longint diff;
    logic   sel;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   checks   = 0;
  int   failures = 0;
  logic stall_prev    = 1'b0;
  logic saw_ready_low = 1'b0;

  mod_bfly_addsub dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .u_i      (u_i),
    .t_i      (t_i),
    .select_i (select_i),
`ifdef MOD_BFLY_HALVE_EN
    .half_i   (half_v),
`endif
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .sum_o    (sum_o),
    .diff_o   (diff_o),
    .select_o (select_o),
    .err_o    (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t model(input longint u, input longint t, input logic sel,
                                 input logic half);
    exp_t   r;
    longint q;
    longint s;
    longint d;
    q = sel ? longint'(QK) : longint'(QD);
    if (u < q && t < q) begin
      s = (u + t) % q;
      d = (u - t + q) % q;
    end else begin
      // Out-of-range operands: one subtract of q from the 24-bit raw value, kept to W bits.
      s = u + t;
      if (s >= q) s = s - q;
      d = (u + q - t) & ((longint'(1) << (W + 1)) - 1);
      if (d >= q) d = d - q;
      s = s & ((longint'(1) << W) - 1);
      d = d & ((longint'(1) << W) - 1);
    end
    if (half) begin
      s = (s % 2 == 1) ? (s + q) / 2 : s / 2;
      d = (d % 2 == 1) ? (d + q) / 2 : d / 2;
    end
    r.sum  = s;
    r.diff = d;
    r.sel  = sel;
    return r;
  endfunction

  always @(negedge clk_i) begin
    if (rst_i) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) check("stall_valid_held", valid_o, 1);
      if (valid_o && ready_i) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got sum=%0d diff=%0d, required no beat", sum_o,
                   diff_o);
        end else begin
          e = sbq.pop_front();
          check("sum", sum_o, e.sum);
          check("diff", diff_o, e.diff);
          check("select", select_o, e.sel);
        end
      end
      if (valid_i && ready_o) sbq.push_back(model(u_i, t_i, select_i, half_v));
      if (!ready_o) saw_ready_low = 1'b1;
      stall_prev = valid_o && !ready_i;
    end
  end

  task automatic send(input int unsigned u, input int unsigned t, input logic sel,
                      input logic h);
    int   n;
    logic acc;
    n        = 0;
    acc      = 1'b0;
    valid_i  = 1'b1;
    u_i      = W'(u);
    t_i      = W'(t);
    select_i = sel;
    half_v   = h;
    do begin
      @(negedge clk_i);
      acc = ready_o;
      @(posedge clk_i);
      #1;
      n++;
    end while (!acc && n < 100);
    if (!acc) check("accept_timeout", 0, 1);
    valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(posedge clk_i);
      n++;
    end
    check("drain_empty", sbq.size(), 0);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned q;
    logic        h;
    logic        done;
    rst_i    = 1'b0;
    valid_i  = 1'b0;
    u_i      = '0;
    t_i      = '0;
    select_i = 1'b0;
    half_v   = 1'b0;
    ready_i  = 1'b1;
    #1 rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;

    @(negedge clk_i);
    check("rst_valid_o", valid_o, 0);
    check("rst_ready_o", ready_o, 1);
    check("rst_err_o", err_o, 0);
    check("rst_sum_o", sum_o, 0);
    check("rst_diff_o", diff_o, 0);
    check("rst_select_o", select_o, 0);
    @(posedge clk_i);
    #1;

    // Kyber example and two-cycle latency.
    send(3000, 500, 1'b1, 1'b0);
    @(negedge clk_i);
    check("latency_c1_valid", valid_o, 0);
    @(negedge clk_i);
    check("latency_c2_valid", valid_o, 1);
    check("latency_c2_sum", sum_o, 171);
    check("latency_c2_diff", diff_o, 2500);
    drain();

    // Dilithium examples including the upper boundary.
    send(5, 10, 1'b0, 1'b0);
    send(8380416, 8380416, 1'b0, 1'b0);
    drain();

    // Back-pressure: stall three cycles from the first valid_o.
    saw_ready_low = 1'b0;
    fork
      begin
        send(100, 3000, 1'b1, 1'b0);
        send(8000000, 1, 1'b0, 1'b0);
        send(3328, 3328, 1'b1, 1'b0);
        send(0, 8380416, 1'b0, 1'b0);
      end
      begin
        int n;
        n = 0;
        while (!valid_o && n < 50) begin
          @(posedge clk_i);
          #1;
          n++;
        end
        ready_i = 1'b0;
        repeat (3) begin
          @(posedge clk_i);
          #1;
        end
        ready_i = 1'b1;
      end
    join
    drain();
    check("bp_ready_low_seen", saw_ready_low, 1);

    // Random in-range traffic, alternating select, random downstream ready.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          q = (i % 2 == 1) ? QK : QD;
          h = 1'b0;
`ifdef MOD_BFLY_HALVE_EN
          h = 1'($urandom_range(0, 1));
`endif
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk_i);
            #1;
          end
          send($urandom_range(0, q - 1), $urandom_range(0, q - 1), (i % 2 == 1), h);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk_i);
          #1;
          ready_i = 1'($urandom_range(0, 1));
        end
        ready_i = 1'b1;
      end
    join
    drain();

    // Out-of-range operand sets the sticky error.
    check("err_before", err_o, 0);
    send(3329, 0, 1'b1, 1'b0);
    @(negedge clk_i);
    check("err_set", err_o, 1);
    repeat (5) @(negedge clk_i);
    check("err_sticky", err_o, 1);
    @(posedge clk_i);
    #1;
    drain();

    // Asynchronous reset with two beats held in flight.
    ready_i = 1'b0;
    send(10, 20, 1'b1, 1'b0);
    send(30, 40, 1'b1, 1'b0);
    @(negedge clk_i);
    check("inflight_valid", valid_o, 1);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    sbq.delete();
    #1;
    check("mid_rst_valid_o", valid_o, 0);
    check("mid_rst_err_o", err_o, 0);
    check("mid_rst_sum_o", sum_o, 0);
    check("mid_rst_diff_o", diff_o, 0);
    check("mid_rst_select_o", select_o, 0);
    check("mid_rst_ready_o", ready_o, 1);
    @(posedge clk_i);
    #1;
    rst_i   = 1'b0;
    ready_i = 1'b1;
    repeat (4) @(negedge clk_i);
    check("post_rst_no_beat", valid_o, 0);
    @(posedge clk_i);
    #1;

`ifdef MOD_BFLY_HALVE_EN
    send(1, 0, 1'b1, 1'b1);
    send(4, 2, 1'b1, 1'b1);
    drain();
`endif

    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
